// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared types and constants for the fetch/data RAM port arbiter.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_RESP,
        D_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } arb_gnt_t;

    localparam int WORD_OFF = 2;

endpackage

// File: rtl/arb_perf_cnt.sv
// arb_perf_cnt: 32-bit saturating event counter with synchronous clear.
module arb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : ((inc && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency single-port RAM between fetch and data ports.
// Defining ARB_PERF_EN adds saturating i-stall, data-access and conflict counters.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic              i_abort,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef ARB_PERF_EN
    output logic [31:0]       perf_istall,
    output logic [31:0]       perf_dacc,
    output logic [31:0]       perf_conflict,
`endif
    input  logic [31:0]       mem_rdata
);

    arb_state_t state_q, state_d;
    arb_gnt_t   gnt;
    logic       abort_q, abort_d;
    logic       wr_q, wr_d;
    logic       i_elig, d_elig;

    // Byte-offset bits and bits above the RAM size are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:ADDR_W+WORD_OFF], i_addr[WORD_OFF-1:0],
                           d_addr[31:ADDR_W+WORD_OFF], d_addr[WORD_OFF-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            wr_q    <= wr_d;
        end
    end

    // The requester being answered this cycle sits out arbitration so its held req is not re-issued.
    always_comb begin
        i_elig    = i_req & ~rst & (state_q != I_RESP);
        d_elig    = d_req & ~rst & (state_q != D_RESP);
        gnt       = d_elig ? GNT_D : (i_elig ? GNT_I : GNT_NONE);
        state_d   = (gnt == GNT_D) ? D_RESP : ((gnt == GNT_I) ? I_RESP : IDLE);
        abort_d   = (gnt == GNT_I) & i_abort;
        wr_d      = (gnt == GNT_D) & (|d_wen);
        mem_en    = gnt != GNT_NONE;
        mem_addr  = (gnt == GNT_D) ? d_addr[ADDR_W+WORD_OFF-1:WORD_OFF] :
                    ((gnt == GNT_I) ? i_addr[ADDR_W+WORD_OFF-1:WORD_OFF] : '0);
        mem_wen   = (gnt == GNT_D) ? d_wen : 4'b0;
        mem_wdata = (gnt == GNT_D) ? d_wdata : 32'b0;
        i_valid   = ~rst & (state_q == I_RESP) & ~abort_q & ~i_abort;
        d_valid   = ~rst & (state_q == D_RESP);
        i_rdata   = i_valid ? mem_rdata : 32'b0;
        d_rdata   = (d_valid & ~wr_q) ? mem_rdata : 32'b0;
        i_stall   = i_req & ~i_valid;
        d_stall   = d_req & ~d_valid;
    end

`ifdef ARB_PERF_EN
    arb_perf_cnt u_cnt_istall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (i_stall),
        .cnt (perf_istall)
    );

    arb_perf_cnt u_cnt_dacc (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (d_valid),
        .cnt (perf_dacc)
    );

    arb_perf_cnt u_cnt_conflict (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (d_elig & i_elig),
        .cnt (perf_conflict)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural 1-cycle RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_abort, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wen;
    logic        i_valid, i_stall, d_valid, d_stall, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_wen;
    logic [9:0]  mem_addr;
    logic [31:0] ram [1024];
    int          vecs = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_abort   (i_abort),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Read-first block RAM with byte enables.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 32'h0;
        ram[1]  = 32'h0BAD_0001;
        ram[4]  = 32'h2008_0005;
        ram[16] = 32'hDEAD_BEEF;
        ram[17] = 32'h1111_1111;
        ram[20] = 32'h5555_0014;
        ram[21] = 32'h6666_0015;
        ram[32] = 32'hCAFE_0001;
        mem_rdata = 32'h0;
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; i_abort = 1'b0;
        d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h40; d_wdata = 32'h0;
        step(); step(); #1;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        // Lone fetch
        step(); rst = 1'b0; d_req = 1'b0; #1;
        chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
        chk("fetch_mem_addr", {22'b0, mem_addr}, 32'd4);
        chk("fetch_mem_wen", {28'b0, mem_wen}, 32'd0);
        chk("fetch_stall0", {31'b0, i_stall}, 32'd1);
        step(); #1;
        chk("fetch_valid", {31'b0, i_valid}, 32'd1);
        chk("fetch_rdata", i_rdata, 32'h2008_0005);
        chk("fetch_stall1", {31'b0, i_stall}, 32'd0);
        chk("fetch_resp_idle", {31'b0, mem_en}, 32'd0);
        // Simultaneous fetch and data read: data first
        step(); d_req = 1'b1; d_addr = 32'h40; #1;
        chk("sim_addr_d", {22'b0, mem_addr}, 32'd16);
        chk("sim_istall0", {31'b0, i_stall}, 32'd1);
        step(); #1;
        chk("sim_d_valid", {31'b0, d_valid}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("sim_istall1", {31'b0, i_stall}, 32'd1);
        chk("sim_addr_i", {22'b0, mem_addr}, 32'd4);
        step(); d_req = 1'b0; #1;
        chk("sim_i_valid", {31'b0, i_valid}, 32'd1);
        chk("sim_i_rdata", i_rdata, 32'h2008_0005);
        chk("sim_d_rdata0", d_rdata, 32'd0);
        // Byte store then read back
        step(); i_req = 1'b0; d_req = 1'b1; d_wen = 4'b0010; d_addr = 32'h44; d_wdata = 32'h0000_AB00; #1;
        chk("st_mem_wen", {28'b0, mem_wen}, 32'h2);
        chk("st_mem_addr", {22'b0, mem_addr}, 32'd17);
        chk("st_mem_wdata", mem_wdata, 32'h0000_AB00);
        step(); #1;
        chk("st_d_valid", {31'b0, d_valid}, 32'd1);
        chk("st_d_rdata", d_rdata, 32'd0);
        chk("st_resp_idle", {31'b0, mem_en}, 32'd0);
        step(); d_wen = 4'h0; d_wdata = 32'h0; #1;
        chk("ld_mem_en", {31'b0, mem_en}, 32'd1);
        step(); #1;
        chk("ld_d_rdata", d_rdata, 32'h1111_AB11);
        // Abort in the response cycle
        step(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10; #1;
        chk("ab_mem_en", {31'b0, mem_en}, 32'd1);
        step(); i_req = 1'b0; i_abort = 1'b1; #1;
        chk("ab_i_valid", {31'b0, i_valid}, 32'd0);
        chk("ab_i_rdata", i_rdata, 32'd0);
        step(); i_abort = 1'b0; i_req = 1'b1; i_addr = 32'h80; #1;
        chk("ab_new_addr", {22'b0, mem_addr}, 32'd32);
        step(); #1;
        chk("ab_new_valid", {31'b0, i_valid}, 32'd1);
        chk("ab_new_rdata", i_rdata, 32'hCAFE_0001);
        // Abort in the issue cycle, then an abort with nothing in flight
        step(); i_addr = 32'h10; i_abort = 1'b1; #1;
        chk("ab2_mem_en", {31'b0, mem_en}, 32'd1);
        step(); i_req = 1'b0; i_abort = 1'b0; #1;
        chk("ab2_i_valid", {31'b0, i_valid}, 32'd0);
        step(); i_abort = 1'b1; #1;
        chk("ab3_mem_en", {31'b0, mem_en}, 32'd0);
        // Address wrap
        step(); i_abort = 1'b0; i_req = 1'b1; i_addr = 32'h0000_1004; #1;
        chk("wrap_addr", {22'b0, mem_addr}, 32'd1);
        step(); #1;
        chk("wrap_rdata", i_rdata, 32'h0BAD_0001);
        // Reset in D_RESP
        step(); i_req = 1'b0; d_req = 1'b1; d_addr = 32'h40; #1;
        chk("rd_mem_en", {31'b0, mem_en}, 32'd1);
        step(); rst = 1'b1; #1;
        chk("rd_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rd_d_rdata", d_rdata, 32'd0);
        chk("rd_mem_en0", {31'b0, mem_en}, 32'd0);
        step(); rst = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10; #1;
        chk("rd_idle_dv", {31'b0, d_valid}, 32'd0);
        chk("rd_first_gnt", {31'b0, mem_en}, 32'd1);
        step(); #1;
        chk("rd_i_valid", {31'b0, i_valid}, 32'd1);
        // Back-to-back alternation
        step(); i_addr = 32'h80; d_req = 1'b1; d_addr = 32'h50; #1;
        chk("bb0_addr", {22'b0, mem_addr}, 32'd20);
        step(); #1;
        chk("bb1_d_rdata", d_rdata, 32'h5555_0014);
        chk("bb1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("bb1_addr", {22'b0, mem_addr}, 32'd32);
        step(); d_addr = 32'h54; #1;
        chk("bb2_i_rdata", i_rdata, 32'hCAFE_0001);
        chk("bb2_mem_en", {31'b0, mem_en}, 32'd1);
        chk("bb2_addr", {22'b0, mem_addr}, 32'd21);
        step(); #1;
        chk("bb3_d_rdata", d_rdata, 32'h6666_0015);
        chk("bb3_addr", {22'b0, mem_addr}, 32'd32);
        step(); d_req = 1'b0; #1;
        chk("bb4_i_valid", {31'b0, i_valid}, 32'd1);
        chk("bb4_mem_en", {31'b0, mem_en}, 32'd0);
        step(); i_req = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
